// File: rtl/temp_mon_pkg.sv
// temp_mon_pkg: register map, status bit layout and sample type for the temperature monitor
package temp_mon_pkg;
  localparam int CH_STRIDE = 'h20;
  localparam int GLOBAL_BASE = 'h100;
  localparam logic [4:0] OFF_LAST = 5'h00;
  localparam logic [4:0] OFF_AVG = 5'h04;
  localparam logic [4:0] OFF_MIN = 5'h08;
  localparam logic [4:0] OFF_MAX = 5'h0C;
  localparam logic [4:0] OFF_THR_HI = 5'h10;
  localparam logic [4:0] OFF_THR_LO = 5'h14;
  localparam int OFF_STATUS = 'h0;
  localparam int OFF_IRQ_EN = 'h4;
  localparam int OFF_CMD = 'h8;
  localparam int STAT_VALID_BASE = 16;
  localparam int SAMPLE_W = 13;
  typedef logic signed [SAMPLE_W-1:0] sample_t;
  function automatic int stat_hi_bit(input int ch);
    return 2 * ch;
  endfunction
  function automatic int stat_lo_bit(input int ch);
    return 2 * ch + 1;
  endfunction
endpackage

// File: rtl/temp_ch_stats.sv
// temp_ch_stats: one channel's last/min/max/block-average, thresholds and alarm-set detection
module temp_ch_stats #(
  parameter int TEMP_W = 13,
  parameter int AVG_LOG2 = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic signed [TEMP_W-1:0] sample_i,
  input  logic                     valid_i,
  input  logic                     clr_i,
  input  logic                     hi_we_i,
  input  logic                     lo_we_i,
  input  logic signed [TEMP_W-1:0] thr_wdata_i,
  output logic signed [TEMP_W-1:0] last_o,
  output logic signed [TEMP_W-1:0] avg_o,
  output logic signed [TEMP_W-1:0] min_o,
  output logic signed [TEMP_W-1:0] max_o,
  output logic signed [TEMP_W-1:0] thr_hi_o,
  output logic signed [TEMP_W-1:0] thr_lo_o,
  output logic                     has_o,
  output logic                     hi_set_o,
  output logic                     lo_set_o
);
  localparam int AW = TEMP_W + AVG_LOG2;
  localparam int CW = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
  logic signed [TEMP_W-1:0] last_q, last_d, avg_q, avg_d, min_q, min_d, max_q, max_d;
  logic signed [TEMP_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic signed [AW-1:0] acc_q, acc_d, acc_base, sum;
  logic [CW-1:0] cnt_q, cnt_d, cnt_base;
  logic has_q, has_d, first, wrap;
  assign last_o = last_q;
  assign avg_o = avg_q;
  assign min_o = min_q;
  assign max_o = max_q;
  assign thr_hi_o = hi_q;
  assign thr_lo_o = lo_q;
  assign has_o = has_q;
  assign hi_set_o = valid_i & (sample_i > hi_q);
  assign lo_set_o = valid_i & (sample_i < lo_q);
  // Fold a sample into the statistics; a clear on the same edge makes it the first post-clear sample
  always_comb begin
    first = ~has_q | clr_i;
    acc_base = clr_i ? '0 : acc_q;
    cnt_base = clr_i ? '0 : cnt_q;
    sum = acc_base + AW'(sample_i);
    wrap = cnt_base == CW'((1 << AVG_LOG2) - 1);
    last_d = valid_i ? sample_i : last_q;
    min_d = valid_i ? ((first || sample_i < min_q) ? sample_i : min_q) : (clr_i ? '0 : min_q);
    max_d = valid_i ? ((first || sample_i > max_q) ? sample_i : max_q) : (clr_i ? '0 : max_q);
    avg_d = (valid_i && wrap) ? TEMP_W'(sum >>> AVG_LOG2) : avg_q;
    acc_d = valid_i ? (wrap ? '0 : sum) : acc_base;
    cnt_d = valid_i ? (wrap ? '0 : cnt_base + CW'(1)) : cnt_base;
    has_d = valid_i | (has_q & ~clr_i);
    hi_d = hi_we_i ? thr_wdata_i : hi_q;
    lo_d = lo_we_i ? thr_wdata_i : lo_q;
  end
  // Statistics and threshold registers; thresholds reset to the widest representable window
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= '0;
      avg_q <= '0;
      min_q <= '0;
      max_q <= '0;
      hi_q <= {1'b0, {(TEMP_W-1){1'b1}}};
      lo_q <= {1'b1, {(TEMP_W-1){1'b0}}};
      acc_q <= '0;
      cnt_q <= '0;
      has_q <= 1'b0;
    end else begin
      last_q <= last_d;
      avg_q <= avg_d;
      min_q <= min_d;
      max_q <= max_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      has_q <= has_d;
    end
  end
endmodule

// File: rtl/temp_apb_monitor.sv
// temp_apb_monitor: APB slave exposing per-channel temperature statistics, sticky alarms and an interrupt
module temp_apb_monitor
  import temp_mon_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int APB_DATA_WIDTH = 32,
  parameter int NUM_CH = 2,
  parameter int TEMP_W = 13,
  parameter int AVG_LOG2 = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [APB_ADDR_WIDTH-1:0] apb_paddr_i,
  input  logic [APB_DATA_WIDTH-1:0] apb_pwdata_i,
  input  logic                      apb_pwrite_i,
  input  logic                      apb_psel_i,
  input  logic                      apb_penable_i,
  output logic [APB_DATA_WIDTH-1:0] apb_prdata_o,
  output logic                      apb_pready_o,
  output logic                      apb_pslverr_o,
  input  logic [NUM_CH*TEMP_W-1:0]  temp_i,
  input  logic [NUM_CH-1:0]         temp_valid_i,
  output logic                      irq_o
);
  localparam int AW = APB_ADDR_WIDTH;
  localparam int DW = APB_DATA_WIDTH;
  localparam int NA = 2 * NUM_CH;
  localparam int CSH = $clog2(CH_STRIDE);
  logic signed [TEMP_W-1:0] last_v[8], avg_v[8], min_v[8], max_v[8], hi_v[8], lo_v[8], ch_val;
  logic [7:0] has_v;
  logic [NA-1:0] alarm_q, alarm_d, en_q, en_d, set_v;
  logic [DW-1:0] prdata_q, prdata_d, rdata;
  logic pready_q, pslverr_q, irq_q;
  logic glob, is_stat, is_en, is_cmd, err, start, wr;
  logic [2:0] ch;
  logic [4:0] off;
  logic unused_ok;
  assign ch = apb_paddr_i[CSH +: 3];
  assign off = apb_paddr_i[CSH-1:0];
  assign glob = apb_paddr_i >= AW'(GLOBAL_BASE);
  assign is_stat = apb_paddr_i == AW'(GLOBAL_BASE + OFF_STATUS);
  assign is_en = apb_paddr_i == AW'(GLOBAL_BASE + OFF_IRQ_EN);
  assign is_cmd = apb_paddr_i == AW'(GLOBAL_BASE + OFF_CMD);
  assign err = (|apb_paddr_i[1:0]) | (glob ? ~(is_stat | is_en | is_cmd) :
               ((32'(ch) >= NUM_CH) | (off > OFF_THR_LO) | (apb_pwrite_i & (off < OFF_THR_HI))));
  assign start = apb_psel_i & apb_penable_i & ~pready_q;
  assign wr = apb_psel_i & apb_penable_i & pready_q & apb_pwrite_i & ~err;
  assign apb_prdata_o = prdata_q;
  assign apb_pready_o = pready_q;
  assign apb_pslverr_o = pslverr_q;
  assign irq_o = irq_q;
  assign unused_ok = ^{apb_pwdata_i, has_v};
  for (genvar i = 0; i < 8; i++) begin : g_ch
    if (i < NUM_CH) begin : g_on
      temp_ch_stats #(.TEMP_W(TEMP_W), .AVG_LOG2(AVG_LOG2)) u_stats (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .sample_i   (temp_i[i*TEMP_W +: TEMP_W]),
        .valid_i    (temp_valid_i[i]),
        .clr_i      (wr & is_cmd & apb_pwdata_i[i]),
        .hi_we_i    (wr & ~glob & (ch == 3'(i)) & (off == OFF_THR_HI)),
        .lo_we_i    (wr & ~glob & (ch == 3'(i)) & (off == OFF_THR_LO)),
        .thr_wdata_i(apb_pwdata_i[TEMP_W-1:0]),
        .last_o     (last_v[i]),
        .avg_o      (avg_v[i]),
        .min_o      (min_v[i]),
        .max_o      (max_v[i]),
        .thr_hi_o   (hi_v[i]),
        .thr_lo_o   (lo_v[i]),
        .has_o      (has_v[i]),
        .hi_set_o   (set_v[stat_hi_bit(i)]),
        .lo_set_o   (set_v[stat_lo_bit(i)])
      );
    end else begin : g_off
      assign last_v[i] = '0;
      assign avg_v[i] = '0;
      assign min_v[i] = '0;
      assign max_v[i] = '0;
      assign hi_v[i] = '0;
      assign lo_v[i] = '0;
      assign has_v[i] = 1'b0;
    end
  end
  // Decode readback, W1C alarm clear (a same-edge set wins) and interrupt enable
  always_comb begin
    ch_val = off == OFF_LAST ? last_v[ch] : off == OFF_AVG ? avg_v[ch] : off == OFF_MIN ? min_v[ch] :
             off == OFF_MAX ? max_v[ch] : off == OFF_THR_HI ? hi_v[ch] : lo_v[ch];
    rdata = glob ? (is_stat ? DW'(alarm_q) | (DW'(has_v[NUM_CH-1:0]) << STAT_VALID_BASE) :
                    is_en ? DW'(en_q) : '0) : DW'(ch_val);
    prdata_d = start ? ((err | apb_pwrite_i) ? '0 : rdata) : prdata_q;
    alarm_d = (alarm_q & ~((wr & is_stat) ? apb_pwdata_i[NA-1:0] : '0)) | set_v;
    en_d = (wr & is_en) ? apb_pwdata_i[NA-1:0] : en_q;
  end
  // One-wait-state APB handshake, sticky alarms and registered interrupt level
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prdata_q <= '0;
      pready_q <= 1'b0;
      pslverr_q <= 1'b0;
      alarm_q <= '0;
      en_q <= '0;
      irq_q <= 1'b0;
    end else begin
      prdata_q <= prdata_d;
      pready_q <= start;
      pslverr_q <= start & err;
      alarm_q <= alarm_d;
      en_q <= en_d;
      irq_q <= |(alarm_q & en_q);
    end
  end
endmodule

// File: tb/tb_temp_apb_monitor.sv
// tb_temp_apb_monitor: directed and randomized APB/sample traffic checked against a behavioural model
module tb_temp_apb_monitor;
  localparam int N = 2;
  localparam int TW = 13;
  localparam int L = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic [11:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic pwrite = 1'b0, psel = 1'b0, penable = 1'b0;
  logic [31:0] prdata;
  logic pready, pslverr, irq;
  logic [N*TW-1:0] temp = '0;
  logic [N-1:0] tvalid = '0;
  int total = 0, bad = 0;
  bit rnd_on = 1'b0;
  temp_apb_monitor #(.APB_ADDR_WIDTH(12), .APB_DATA_WIDTH(32), .NUM_CH(N), .TEMP_W(TW), .AVG_LOG2(L)) dut (
    .clk_i(clk), .rst_i(rst), .apb_paddr_i(paddr), .apb_pwdata_i(pwdata), .apb_pwrite_i(pwrite),
    .apb_psel_i(psel), .apb_penable_i(penable), .apb_prdata_o(prdata), .apb_pready_o(pready),
    .apb_pslverr_o(pslverr), .temp_i(temp), .temp_valid_i(tvalid), .irq_o(irq)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask
  // behavioural model: plain integers per channel, sticky alarm word, expected APB response
  int m_last[N], m_avg[N], m_min[N], m_max[N], m_hi[N], m_lo[N], m_sum[N], m_cnt[N];
  bit m_has[N];
  bit [31:0] m_alarm, m_en, m_sets;
  logic [31:0] m_rdata;
  bit m_pready, m_err, m_irq, m_rdchk, m_start, m_wr, m_irqn;
  int ms;
  function automatic int sext(input int v);
    int x;
    x = v & ((1 << TW) - 1);
    return (x >= (1 << (TW - 1))) ? x - (1 << TW) : x;
  endfunction
  function automatic int fdiv(input int s, input int n);
    int q;
    q = s / n;
    if ((s % n) != 0 && s < 0) q = q - 1;
    return q;
  endfunction
  function automatic bit addr_err(input int a, input bit w);
    if (a % 4 != 0) return 1'b1;
    if (a >= 256) return !(a == 256 || a == 260 || a == 264);
    return (a / 32 >= N) || (a % 32 > 20) || (w && a % 32 < 16);
  endfunction
  function automatic logic [31:0] rd_val(input int a);
    logic [31:0] v;
    int c;
    if (a == 256) begin
      v = m_alarm;
      for (int k = 0; k < N; k++) if (m_has[k]) v = v | (32'd1 << (16 + k));
      return v;
    end
    if (a == 260) return m_en;
    if (a >= 256) return 32'd0;
    c = a / 32;
    case (a % 32)
      0: return m_last[c];
      4: return m_avg[c];
      8: return m_min[c];
      12: return m_max[c];
      16: return m_hi[c];
      default: return m_lo[c];
    endcase
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < N; c++) begin
        m_last[c] = 0; m_avg[c] = 0; m_min[c] = 0; m_max[c] = 0; m_sum[c] = 0; m_cnt[c] = 0;
        m_hi[c] = (1 << (TW - 1)) - 1; m_lo[c] = -(1 << (TW - 1)); m_has[c] = 1'b0;
      end
      m_alarm = 0; m_en = 0; m_pready = 0; m_err = 0; m_irq = 0; m_rdchk = 0; m_rdata = 0;
    end else begin
      m_start = psel && penable && !m_pready;
      m_wr = psel && penable && m_pready && pwrite && !addr_err(int'(paddr), pwrite);
      m_irqn = |(m_alarm & m_en);
      if (m_start) begin
        m_err = addr_err(int'(paddr), pwrite);
        m_rdchk = !pwrite && !m_err;
        m_rdata = rd_val(int'(paddr));
      end
      m_sets = 0;
      for (int c = 0; c < N; c++) begin
        ms = sext(int'(temp[c*TW +: TW]));
        if (tvalid[c] && ms > m_hi[c]) m_sets[2*c] = 1'b1;
        if (tvalid[c] && ms < m_lo[c]) m_sets[2*c+1] = 1'b1;
      end
      if (m_wr) begin
        if (paddr == 256) m_alarm = m_alarm & ~pwdata;
        else if (paddr == 260) m_en = pwdata & ((1 << (2 * N)) - 1);
        else if (paddr == 264) begin
          for (int c = 0; c < N; c++) if (pwdata[c]) begin
            m_has[c] = 0; m_min[c] = 0; m_max[c] = 0; m_sum[c] = 0; m_cnt[c] = 0;
          end
        end else if (paddr % 32 == 16) m_hi[paddr/32] = sext(int'(pwdata));
        else m_lo[paddr/32] = sext(int'(pwdata));
      end
      m_alarm = m_alarm | m_sets;
      for (int c = 0; c < N; c++) if (tvalid[c]) begin
        ms = sext(int'(temp[c*TW +: TW]));
        m_last[c] = ms;
        m_min[c] = (!m_has[c] || ms < m_min[c]) ? ms : m_min[c];
        m_max[c] = (!m_has[c] || ms > m_max[c]) ? ms : m_max[c];
        m_has[c] = 1'b1;
        m_sum[c] += ms;
        m_cnt[c]++;
        if (m_cnt[c] == (1 << L)) begin
          m_avg[c] = fdiv(m_sum[c], 1 << L);
          m_sum[c] = 0;
          m_cnt[c] = 0;
        end
      end
      m_pready = m_start;
      m_irq = m_irqn;
    end
  end
  // compare DUT outputs against the model every cycle
  always @(negedge clk) begin
    check("pready", {31'd0, pready}, {31'd0, m_pready});
    check("irq", {31'd0, irq}, {31'd0, m_irq});
    if (m_pready) begin
      check("pslverr", {31'd0, pslverr}, {31'd0, m_err});
      if (m_rdchk) check("prdata", prdata, m_rdata);
    end
  end
  task automatic step();
    @(negedge clk);
    for (int c = 0; c < N; c++) begin
      tvalid[c] = rnd_on && ($urandom_range(0, 2) == 0);
      temp[c*TW +: TW] = TW'(int'($urandom_range(0, 1200)) - 600);
    end
  endtask
  task automatic apb(input bit w, input int a, input logic [31:0] d, input int sch, input int sv,
                     output logic [31:0] rd, output logic er);
    int waits;
    paddr = 12'(a); pwrite = w; pwdata = d; psel = 1'b1; penable = 1'b0;
    step();
    penable = 1'b1;
    waits = 0;
    do begin
      step();
      waits++;
    end while (!pready && waits < 6);
    check("wait_states", waits, 1);
    rd = prdata;
    er = pslverr;
    if (sch >= 0) begin
      tvalid[sch] = 1'b1;
      temp[sch*TW +: TW] = TW'(sv);
    end
    step();
    psel = 1'b0; penable = 1'b0;
  endtask
  task automatic rd_chk(input string nm, input int a, input logic [31:0] exp, input bit exp_err);
    logic [31:0] r;
    logic e;
    apb(1'b0, a, 32'd0, -1, 0, r, e);
    check({nm, "_err"}, {31'd0, e}, {31'd0, exp_err});
    if (!exp_err) check(nm, r, exp);
  endtask
  task automatic wr_op(input int a, input logic [31:0] d, input int sch, input int sv, input bit exp_err);
    logic [31:0] r;
    logic e;
    apb(1'b1, a, d, sch, sv, r, e);
    check("wr_err", {31'd0, e}, {31'd0, exp_err});
  endtask
  task automatic sample(input int c, input int v);
    tvalid[c] = 1'b1;
    temp[c*TW +: TW] = TW'(v);
    step();
  endtask
  initial begin
    logic [31:0] r;
    logic e;
    int k, a;
    repeat (3) @(negedge clk);
    check("rst_prdata", prdata, 0);
    check("rst_pready", {31'd0, pready}, 0);
    check("rst_pslverr", {31'd0, pslverr}, 0);
    check("rst_irq", {31'd0, irq}, 0);
    rst = 1'b0;
    rd_chk("thr_hi0", 'h010, 32'h00000FFF, 0);
    rd_chk("thr_lo0", 'h014, 32'hFFFFF000, 0);
    rd_chk("status0", 'h100, 32'h0, 0);
    sample(0, 400); sample(0, 416); sample(0, 384); sample(0, -16);
    rd_chk("last0", 'h000, 32'hFFFFFFF0, 0);
    rd_chk("min0", 'h008, 32'hFFFFFFF0, 0);
    rd_chk("max0", 'h00C, 32'd416, 0);
    rd_chk("avg0", 'h004, 32'd296, 0);
    rd_chk("status_valid", 'h100, 32'h00010000, 0);
    wr_op('h030, 32'd480, -1, 0, 0);
    wr_op('h104, 32'h4, -1, 0, 0);
    tvalid[1] = 1'b1;
    temp[TW +: TW] = TW'(481);
    step();
    check("irq_edge1", {31'd0, irq}, 0);
    step();
    check("irq_edge2", {31'd0, irq}, 1);
    rd_chk("status_hi1", 'h100, 32'h00030004, 0);
    wr_op('h100, 32'h4, -1, 0, 0);
    step();
    check("irq_fall", {31'd0, irq}, 0);
    wr_op('h100, 32'h4, 1, 500, 0);
    rd_chk("status_setwins", 'h100, 32'h00030004, 0);
    wr_op('h108, 32'h1, 0, 100, 0);
    rd_chk("min_clr", 'h008, 32'd100, 0);
    rd_chk("max_clr", 'h00C, 32'd100, 0);
    sample(0, 100); sample(0, 100); sample(0, 100);
    rd_chk("avg_clr", 'h004, 32'd100, 0);
    rd_chk("err_unaligned", 'h002, 32'h0, 1);
    rd_chk("err_ch2", 'h040, 32'h0, 1);
    wr_op('h000, 32'd5, -1, 0, 1);
    rd_chk("last_kept", 'h000, 32'd100, 0);
    paddr = 12'h010; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    step();
    penable = 1'b1;
    rst = 1'b1;
    step();
    check("abort_pready", {31'd0, pready}, 0);
    psel = 1'b0; penable = 1'b0;
    step();
    rst = 1'b0;
    step();
    check("abort_pready2", {31'd0, pready}, 0);
    check("abort_irq", {31'd0, irq}, 0);
    rd_chk("rst_thr_hi1", 'h030, 32'h00000FFF, 0);
    rd_chk("rst_thr_lo1", 'h034, 32'hFFFFF000, 0);
    rd_chk("rst_status", 'h100, 32'h0, 0);
    rd_chk("rst_irq_en", 'h104, 32'h0, 0);
    rd_chk("rst_last0", 'h000, 32'h0, 0);
    rd_chk("rst_min0", 'h008, 32'h0, 0);
    rd_chk("cmd_reads0", 'h108, 32'h0, 0);
    rnd_on = 1'b1;
    repeat (400) begin
      k = $urandom_range(0, 9);
      if (k < 6) a = $urandom_range(0, 2) * 32 + 4 * $urandom_range(0, 6);
      else if (k == 6) a = 'h100;
      else if (k == 7) a = 'h104;
      else if (k == 8) a = ($urandom_range(0, 3) == 0) ? 'h10C : 'h108;
      else a = $urandom_range(0, 4095);
      apb(1'($urandom_range(0, 1)), a, $urandom, -1, 0, r, e);
      repeat ($urandom_range(0, 2)) step();
    end
    rnd_on = 1'b0;
    step();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
